// File: rtl/osc_prog_divider.sv
// Programmable clock divider: near-50% duty divided clock, binary taps, and a
// load/ready divisor handshake applied on period boundaries. Optional DIV_TICK_EN adds tick_o.
module osc_prog_divider #(
  parameter int CNT_W     = 8,
  parameter int TAPS      = 4,
  parameter int DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load,
  output logic             div_ready,
  output logic [CNT_W-1:0] div_cur_o,
  output logic             clk_div_o,
  output logic [TAPS-1:0]  taps_o
`ifdef DIV_TICK_EN
  ,
  output logic             tick_o
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             clk_div_q, clk_div_d;
  logic [TAPS-1:0]  taps_q, taps_d;
`ifdef DIV_TICK_EN
  logic             tick_q, tick_d;
`endif

  logic             wrap;
  logic [CNT_W:0]   half_len;
  logic [CNT_W-1:0] div_clamped;

  // One extra bit keeps ceil(N/2) exact when N is at its maximum.
  assign half_len    = ({1'b0, div_cur_q} + (CNT_W+1)'(1)) >> 1;
  assign wrap        = (cnt_q == div_cur_q - CNT_W'(1));
  assign div_clamped = (div_i < CNT_W'(2)) ? CNT_W'(2) : div_i;

  // NOTE: every next-state signal gets a default first so this block cannot infer a latch.
  always_comb begin
    cnt_d     = cnt_q;
    clk_div_d = clk_div_q;
    taps_d    = taps_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    ready_d   = ready_q;
`ifdef DIV_TICK_EN
    tick_d    = 1'b0;
`endif

    if (en) begin
      cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
      clk_div_d = ({1'b0, cnt_d} < half_len);
      if (!clk_div_q && clk_div_d) taps_d = taps_q + TAPS'(1);
`ifdef DIV_TICK_EN
      tick_d    = wrap;
`endif
    end else begin
      cnt_d     = '0;
      clk_div_d = 1'b0;
    end

    // A load seen on a boundary edge lands in pending only; it waits for the next boundary.
    if (ready_q) begin
      if (div_load) begin
        pend_d  = div_clamped;
        ready_d = 1'b0;
      end
    end else if (!en || wrap) begin
      div_cur_d = pend_q;
      ready_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
      taps_q    <= '0;
      div_cur_q <= CNT_W'(DIV_RESET);
      pend_q    <= '0;
      ready_q   <= 1'b1;
`ifdef DIV_TICK_EN
      tick_q    <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
      taps_q    <= taps_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
`ifdef DIV_TICK_EN
      tick_q    <= tick_d;
`endif
    end
  end

  assign div_ready = ready_q;
  assign div_cur_o = div_cur_q;
  assign clk_div_o = clk_div_q;
  assign taps_o    = taps_q;
`ifdef DIV_TICK_EN
  assign tick_o    = tick_q;
`endif

endmodule

// File: tb/tb_osc_prog_divider.sv
// Randomised self-checking bench for osc_prog_divider; the reference holds the expected
// output waveform of the current period as a queue of levels.
module tb_osc_prog_divider;

  localparam int CNT_W = 8;
  localparam int TAPS  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_i;
  logic             div_load;
  logic             div_ready;
  logic [CNT_W-1:0] div_cur_o;
  logic             clk_div_o;
  logic [TAPS-1:0]  taps_o;
`ifdef DIV_TICK_EN
  logic             tick_o;
`endif

  osc_prog_divider #(.CNT_W(CNT_W), .TAPS(TAPS), .DIV_RESET(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_i     (div_i),
    .div_load  (div_load),
    .div_ready (div_ready),
    .div_cur_o (div_cur_o),
    .clk_div_o (clk_div_o),
    .taps_o    (taps_o)
`ifdef DIV_TICK_EN
    ,
    .tick_o    (tick_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference: remaining output levels of the current period, front = present level.
  bit wave[$];
  int m_cur, m_pend, m_taps;
  bit m_ready, m_tick;

  function automatic int clamp(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  // Period entered from cnt=0 with the output low: first high cycle is lost.
  function automatic void load_first(input int n);
    int h = (n + 1) / 2;
    wave.delete();
    wave.push_back(1'b0);
    for (int i = 1; i < h; i++) wave.push_back(1'b1);
    for (int i = h; i < n; i++) wave.push_back(1'b0);
  endfunction

  function automatic void load_full(input int n);
    int h = (n + 1) / 2;
    wave.delete();
    for (int i = 0; i < h; i++) wave.push_back(1'b1);
    for (int i = h; i < n; i++) wave.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    bit boundary = 1'b0;
    bit prev_out;
    if (rst) begin
      m_cur = 2; m_pend = 0; m_ready = 1'b1; m_taps = 0; m_tick = 1'b0;
      load_first(2);
      return;
    end
    prev_out = wave[0];
    if (en) begin
      boundary = (wave.size() == 1);
      void'(wave.pop_front());
    end
    if (m_ready) begin
      if (div_load) begin
        m_pend  = clamp(int'(div_i));
        m_ready = 1'b0;
      end
    end else if (!en || boundary) begin
      m_cur   = m_pend;
      m_ready = 1'b1;
    end
    if (!en) load_first(m_cur);
    else if (boundary) load_full(m_cur);
    m_tick = en && boundary;
    if (en && !prev_out && wave[0]) m_taps = (m_taps + 1) % (1 << TAPS);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("clk_div_o", 32'(clk_div_o), 32'(wave[0]));
    check("taps_o",    32'(taps_o),    32'(m_taps));
    check("div_cur_o", 32'(div_cur_o), 32'(m_cur));
    check("div_ready", 32'(div_ready), 32'(m_ready));
`ifdef DIV_TICK_EN
    check("tick_o",    32'(tick_o),    32'(m_tick));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int n);
    div_i    = CNT_W'(n);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  // Advance until the next edge is a period boundary, bounded.
  task automatic wait_boundary();
    int k = 0;
    while (wave.size() != 1 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("boundary_wait", 32'(wave.size()), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_i = '0; div_load = 1'b0;
    m_cur = 2; m_pend = 0; m_ready = 1'b1; m_taps = 0; m_tick = 1'b0;
    load_first(2);
    run(2);

    // Default divisor 2 with taps.
    rst = 1'b0; en = 1'b1;
    run(70);

    // N=5 mid-period, then N=0 and N=1 (both clamp to 2).
    step();
    load(5);  run(25);
    load(0);  run(12);
    load(1);  run(12);

    // N=7 accepted on a boundary edge; N=3 while not ready is ignored.
    wait_boundary();
    div_i = CNT_W'(7); div_load = 1'b1; step();
    div_i = CNT_W'(3); step();
    div_load = 1'b0;
    run(30);

    // N=9 pending while disabled for 10 cycles, then re-enable.
    load(9);
    en = 1'b0; run(10);
    en = 1'b1; run(30);

    // Reset mid-period with a load pending.
    load(4);
    step();
    rst = 1'b1; step();
    rst = 1'b0; run(20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 19) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_i    = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 255))
                                             : CNT_W'($urandom_range(0, 12));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
